// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response channel between the fetch stage and imem.
interface fetch_stage_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  // Fetch stage side: issues requests and consumes responses.
  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  // Memory side: accepts requests and returns instruction words.
  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );
endinterface

// File: rtl/fetch_stage.sv
// Fetch stage: PC generation, single-outstanding imem handshake and the
// producer half of the IF/ID register, with stall back-pressure and redirect flush.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          redirect_valid,
  input  logic [31:0]   redirect_pc,
  fetch_stage_if.master imem,
  output logic [31:0]   pre_address_pc,
  output logic [31:0]   instruction_fetch,
  output logic          fetch_valid
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,  // request may be issued at pc
    S_WAIT = 2'd1,  // request accepted, waiting for the response
    S_HOLD = 2'd2,  // response parked in the skid register, ibuf full
    S_DROP = 2'd3   // outstanding response belongs to a flushed path
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            valid;
  } ibuf_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  ibuf_t           ibuf_q, ibuf_d;
  logic [XLEN-1:0] skid_q, skid_d;

  logic            consume_c;
  logic            space_c;
  logic            req_valid_c;

  // IF/ID takes the buffered pair this cycle; ibuf can accept a load this cycle.
  assign consume_c = ibuf_q.valid & ~stall;
  assign space_c   = ~ibuf_q.valid | consume_c;

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      ibuf_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ibuf_q  <= ibuf_d;
      skid_q  <= skid_d;
    end
  end

  // Next-state, ibuf/pc update and request valid; redirect overrides everything.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ibuf_d      = ibuf_q;
    skid_d      = skid_q;
    req_valid_c = 1'b0;

    if (consume_c) begin
      ibuf_d.valid = 1'b0;
    end

    if (redirect_valid) begin
      ibuf_d.valid = 1'b0;
      pc_d         = redirect_pc;
      case (state_q)
        // A response still in flight must be swallowed unless it lands right now.
        S_WAIT, S_DROP: state_d = imem.imem_rsp_valid ? S_REQ : S_DROP;
        default:        state_d = S_REQ;
      endcase
    end else begin
      case (state_q)
        S_REQ: begin
          req_valid_c = 1'b1;
          if (imem.imem_req_ready) begin
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem.imem_rsp_valid) begin
            if (space_c) begin
              ibuf_d.pc    = pc_q;
              ibuf_d.instr = imem.imem_rsp_data;
              ibuf_d.valid = 1'b1;
              pc_d         = pc_q + PC_STEP;
              state_d      = S_REQ;
            end else begin
              skid_d  = imem.imem_rsp_data;
              state_d = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (space_c) begin
            ibuf_d.pc    = pc_q;
            ibuf_d.instr = skid_q;
            ibuf_d.valid = 1'b1;
            pc_d         = pc_q + PC_STEP;
            state_d      = S_REQ;
          end
        end
        S_DROP: begin
          if (imem.imem_rsp_valid) begin
            state_d = S_REQ;
          end
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  // Request channel: address is the pc register, held until accepted.
  assign imem.imem_req_valid = req_valid_c;
  assign imem.imem_req_addr  = pc_q;

  // Presented pair comes straight from ibuf; a bubble shows the NOP encoding.
  assign pre_address_pc    = ibuf_q.pc;
  assign instruction_fetch = ibuf_q.valid ? ibuf_q.instr : NOP_INSTR;
  assign fetch_valid       = ibuf_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a latency-programmable imem model pushes
// each live response, and every instruction taken by IF/ID is popped and compared.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } pair_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] pre_address_pc;
  logic [31:0] instruction_fetch;
  logic        fetch_valid;

  fetch_stage_if imem ();

  fetch_stage #(
    .RESET_PC  (RESET_PC),
    .NOP_INSTR (NOP_INSTR)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .stall             (stall),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .imem              (imem.master),
    .pre_address_pc    (pre_address_pc),
    .instruction_fetch (instruction_fetch),
    .fetch_valid       (fetch_valid)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  pair_t       exp_q[$];
  logic [31:0] pres_pc[$];
  int          cyc = 0;

  // sampled mid-cycle
  logic        s_valid, s_req_valid, s_hs;
  logic [31:0] s_pc, s_instr, s_req_addr;

  // imem model
  int          lat = 1;
  logic        pend = 1'b0;
  logic        pend_stale = 1'b0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = '0;

  logic [31:0] exp_req = RESET_PC;
  logic [31:0] prev_hs_addr = '0;
  int          hs_count = 0;
  logic        saw_wrap = 1'b0;
  logic        gap_chk = 1'b0;
  int          prev_cons = -1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5C3_0F00;
  endfunction

  // One clock: sample and score at negedge, then advance memory after posedge.
  task automatic cycle();
    pair_t e;
    @(negedge clk);
    s_valid     = fetch_valid;
    s_pc        = pre_address_pc;
    s_instr     = instruction_fetch;
    s_req_valid = imem.imem_req_valid;
    s_req_addr  = imem.imem_req_addr;
    s_hs        = s_req_valid & imem.imem_req_ready & ~rst;
    if (!rst) begin
      if (!s_valid) begin
        check("nop_instr", s_instr, NOP_INSTR);
      end else if (!stall && !redirect_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("pc", s_pc, e.pc);
          check("instr", s_instr, e.instr);
        end
        pres_pc.push_back(s_pc);
        if (gap_chk && prev_cons >= 0) check("gap", 32'(cyc - prev_cons), 32'd2);
        prev_cons = cyc;
      end
      if (s_hs) begin
        check("req_addr", s_req_addr, exp_req);
        if (prev_hs_addr == 32'hFFFF_FFFC && s_req_addr == 32'h0) saw_wrap = 1'b1;
        prev_hs_addr = s_req_addr;
        exp_req      = exp_req + 32'd4;
        hs_count++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    imem.imem_rsp_valid = 1'b0;
    if (s_hs) begin
      pend       = 1'b1;
      pend_stale = 1'b0;
      pend_cnt   = lat;
      pend_addr  = s_req_addr;
    end
    if (pend) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        pend                = 1'b0;
        imem.imem_rsp_valid = 1'b1;
        imem.imem_rsp_data  = mem_word(pend_addr);
        if (!pend_stale) exp_q.push_back('{pc: pend_addr, instr: mem_word(pend_addr)});
      end
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    exp_q.delete();
    if (pend) pend_stale = 1'b1;
    exp_req = RESET_PC;
    repeat (n) cycle();
    check("rst_valid", 32'(fetch_valid), 32'd0);
    check("rst_pc", pre_address_pc, 32'd0);
    check("rst_instr", instruction_fetch, NOP_INSTR);
    check("rst_req_valid", 32'(imem.imem_req_valid), 32'd1);
    check("rst_req_addr", imem.imem_req_addr, RESET_PC);
    rst = 1'b0;
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    exp_q.delete();
    if (pend) pend_stale = 1'b1;
    exp_req = pc;
    cycle();
    redirect_valid = 1'b0;
  endtask

  task automatic wait_hs();
    int n = 0;
    cycle();
    while (!s_hs && n < 20) begin cycle(); n++; end
    check("hs_timeout", 32'(s_hs), 32'd1);
  endtask

  task automatic wait_presented(input int target);
    int n = 0;
    while (pres_pc.size() < target && n < 40) begin cycle(); n++; end
    check("present_timeout", 32'(pres_pc.size() >= target), 32'd1);
  endtask

  initial begin
    logic [31:0] held;
    logic [31:0] addr0;
    int          hs0;
    int          n;

    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem.imem_req_ready = 1'b1; imem.imem_rsp_valid = 1'b0; imem.imem_rsp_data = '0;

    // 1: sequential fetch, one instruction every two clocks
    do_reset(3);
    gap_chk = 1'b1;
    wait_presented(3);
    gap_chk = 1'b0;
    check("seq_pc0", pres_pc[0], 32'h0);
    check("seq_pc1", pres_pc[1], 32'h4);
    check("seq_pc2", pres_pc[2], 32'h8);

    // 2: stall while next response lands -> skid, nothing lost
    n = 0;
    while (!fetch_valid && n < 10) begin cycle(); n++; end
    stall = 1'b1;
    held  = pre_address_pc;
    repeat (4) begin
      cycle();
      check("stall_valid", 32'(s_valid), 32'd1);
      check("stall_pc", s_pc, held);
    end
    stall = 1'b0;
    cycle();
    cycle();
    check("after_stall_valid", 32'(s_valid), 32'd1);
    check("after_stall_pc", s_pc, held + 32'd4);

    // 5: memory not ready for 5 clocks -> request held stable, one accept
    imem.imem_req_ready = 1'b0;
    n = 0;
    cycle();
    while (!s_req_valid && n < 10) begin cycle(); n++; end
    addr0 = s_req_addr;
    hs0   = hs_count;
    repeat (5) begin
      cycle();
      check("busy_req_valid", 32'(s_req_valid), 32'd1);
      check("busy_req_addr", s_req_addr, addr0);
    end
    check("busy_no_accept", 32'(hs_count), 32'(hs0));
    imem.imem_req_ready = 1'b1;
    cycle();
    cycle();
    check("one_accept", 32'(hs_count), 32'(hs0 + 1));

    // 3: redirect while waiting, response two clocks later is dropped
    lat = 2;
    wait_hs();
    n = pres_pc.size();
    do_redirect(32'h0000_0100);
    cycle();
    check("drop_req_valid", 32'(s_req_valid), 32'd0);
    wait_presented(n + 1);
    check("redirect_first_pc", pres_pc[pres_pc.size() - 1], 32'h0000_0100);

    // 4: redirect coinciding with the response -> straight back to REQ
    lat = 1;
    wait_hs();
    do_redirect(32'h0000_0200);
    cycle();
    check("no_drop_req_valid", 32'(s_req_valid), 32'd1);
    check("no_drop_req_addr", s_req_addr, 32'h0000_0200);

    // pc wrap at the top of the address space
    do_redirect(32'hFFFF_FFF8);
    n = 0;
    while (!saw_wrap && n < 20) begin cycle(); n++; end
    check("wrap", 32'(saw_wrap), 32'd1);

    // 6: reset during WAIT, stale response after reset is ignored
    lat = 3;
    wait_hs();
    imem.imem_req_ready = 1'b0;
    n = pres_pc.size();
    do_reset(1);
    cycle();
    cycle();
    imem.imem_req_ready = 1'b1;
    lat = 1;
    wait_presented(n + 1);
    check("post_rst_pc", pres_pc[pres_pc.size() - 1], RESET_PC);

    // drain: nothing expected may remain unpresented
    imem.imem_req_ready = 1'b0;
    repeat (12) cycle();
    check("drain", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
